// File: rtl/matrix_elementwise_mxp_if.sv
// Handshake/bus bundle for matrix_elementwise_mxp: operand write ports, run control, result stream.
interface matrix_elementwise_mxp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a_in, b_in;
  logic [IDX_W-1:0]      a_addr, b_addr;
  logic                  a_wen, b_wen;
  logic [DATA_WIDTH-1:0] c_out;
  logic [IDX_W-1:0]      c_idx;
  logic                  c_valid, c_ready;
  logic                  busy, done, ovf;

  modport master (
    output start, op, a_in, b_in, a_addr, b_addr, a_wen, b_wen, c_ready,
    input  c_out, c_idx, c_valid, busy, done, ovf
  );
  modport slave (
    input  start, op, a_in, b_in, a_addr, b_addr, a_wen, b_wen, c_ready,
    output c_out, c_idx, c_valid, busy, done, ovf
  );
endinterface

// File: rtl/matrix_elementwise_mxp.sv
// M x P element-wise engine: A+B, A-B, B-A, (A+B)>>>1, streamed row-major with valid/ready.
// Optional MATRIX_SATURATE_EN clamps overflowing results instead of wrapping.
module matrix_elementwise_mxp #(
  parameter int M          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input logic clk,
  input logic rst,
  matrix_elementwise_mxp_if.slave bus
);
  localparam int DEPTH = M * P;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, c_idx_q, c_idx_d;
  logic [1:0]            op_q, op_d;
  logic                  ovf_q, ovf_d, c_valid_q, c_valid_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] c_out_q, c_out_d;

  logic [DATA_WIDTH-1:0] a_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem_q [DEPTH];

  logic idle;
  assign idle = (state_q == S_IDLE);

  // Operand storage has no reset; writes only land while idle (including the start cycle).
  always_ff @(posedge clk) begin
    if (bus.a_wen && idle && ({1'b0, bus.a_addr} < DEPTH_W)) a_mem_q[bus.a_addr] <= bus.a_in;
    if (bus.b_wen && idle && ({1'b0, bus.b_addr} < DEPTH_W)) b_mem_q[bus.b_addr] <= bus.b_in;
  end

  logic signed [DATA_WIDTH:0] a_x, b_x, sum_x, wide;
  logic                       elem_ovf;
  logic [DATA_WIDTH-1:0]      res;

  always_comb begin
    a_x   = {a_mem_q[idx_q][DATA_WIDTH-1], a_mem_q[idx_q]};
    b_x   = {b_mem_q[idx_q][DATA_WIDTH-1], b_mem_q[idx_q]};
    sum_x = a_x + b_x;
    case (op_q)
      2'b00:   wide = sum_x;
      2'b01:   wide = a_x - b_x;
      2'b10:   wide = b_x - a_x;
      default: wide = sum_x >>> 1;
    endcase
    // Fits in DATA_WIDTH only when the two top bits agree; the mean always does.
    elem_ovf = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
`ifdef MATRIX_SATURATE_EN
    if (elem_ovf) res = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    else          res = wide[DATA_WIDTH-1:0];
`else
    res = wide[DATA_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    ovf_d     = ovf_q;
    c_out_d   = c_out_q;
    c_idx_d   = c_idx_q;
    c_valid_d = c_valid_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_RUN;
        idx_d   = '0;
        op_d    = bus.op;
        ovf_d   = 1'b0;
      end
      S_RUN: if (!c_valid_q || bus.c_ready) begin
        c_out_d   = res;
        c_idx_d   = idx_q;
        c_valid_d = 1'b1;
        idx_d     = idx_q + 1'b1;
        ovf_d     = ovf_q | elem_ovf;
        if (idx_q == LAST_IDX) state_d = S_FLUSH;
      end
      S_FLUSH: if (c_valid_q && bus.c_ready) begin
        c_valid_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      ovf_q     <= 1'b0;
      c_out_q   <= '0;
      c_idx_q   <= '0;
      c_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      ovf_q     <= ovf_d;
      c_out_q   <= c_out_d;
      c_idx_q   <= c_idx_d;
      c_valid_q <= c_valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.c_out   = c_out_q;
  assign bus.c_idx   = c_idx_q;
  assign bus.c_valid = c_valid_q;
  assign bus.busy    = !idle;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_matrix_elementwise_mxp.sv
// Randomized self-checking bench for matrix_elementwise_mxp against a longint arithmetic model.
module tb_matrix_elementwise_mxp;
  localparam int M = 3, P = 3, DW = 32, IW = 4, DEPTH = M * P;
  localparam longint MAXV = 64'sd2147483647, MINV = -64'sd2147483648;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  matrix_elementwise_mxp_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus ();
  matrix_elementwise_mxp #(.M(M), .P(P), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic signed [DW-1:0] ma [DEPTH];
  logic signed [DW-1:0] mb [DEPTH];
  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] obs [DEPTH];
  bit   exp_ovf, ovf_at_done, done_seen, chk_en = 1'b0;
  int   exp_i, hs, done_cyc, start_cyc;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                       output logic signed [DW-1:0] r, output bit v);
    longint s;
    case (o)
      2'd0:    s = longint'(a) + longint'(b);
      2'd1:    s = longint'(a) - longint'(b);
      2'd2:    s = longint'(b) - longint'(a);
      default: s = (longint'(a) + longint'(b)) >>> 1;
    endcase
    v = (s > MAXV) || (s < MINV);
`ifdef MATRIX_SATURATE_EN
    r = v ? ((s > 0) ? 32'sh7fffffff : 32'sh80000000) : DW'(s);
`else
    r = DW'(s);
`endif
  endtask

  // Compare process: every cycle the outputs are sampled on the falling edge.
  initial begin
    bit prev_v, prev_r, prev_d;
    logic [DW-1:0] prev_out;
    logic [IW-1:0] prev_idx;
    prev_v = 0; prev_r = 0; prev_d = 0; prev_out = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!chk_en || rst) begin
        prev_v = 0; prev_d = 0;
      end else begin
        if (bus.c_valid && bus.done) chk("valid_done_overlap", 1, 0);
        if (bus.c_valid) begin
          if (prev_v && !prev_r) begin
            chk("hold_c_out", bus.c_out, prev_out);
            chk("hold_c_idx", bus.c_idx, prev_idx);
          end
          if (exp_q.size() == 0) chk("extra_output", 1, 0);
          else begin
            chk("c_out", $signed(bus.c_out), exp_q[0]);
            chk("c_idx", bus.c_idx, exp_i);
            if (bus.c_ready) begin
              if (hs < DEPTH) obs[hs] = bus.c_out;
              hs++; exp_i++;
              void'(exp_q.pop_front());
            end
          end
        end
        if (bus.done) begin
          if (prev_d) chk("done_width", 2, 1);
          done_seen = 1; done_cyc = cyc; ovf_at_done = bus.ovf;
          chk("outputs_before_done", exp_q.size(), 0);
          chk("busy_at_done", bus.busy, 0);
          chk("ovf", bus.ovf, exp_ovf);
        end
        prev_v = bus.c_valid; prev_r = bus.c_ready; prev_d = bus.done;
        prev_out = bus.c_out; prev_idx = bus.c_idx;
      end
    end
  end

  task automatic wr(input bit isb, input int addr, input logic [DW-1:0] v);
    @(posedge clk); #1;
    if (isb) begin bus.b_wen = 1; bus.b_addr = IW'(addr); bus.b_in = v; end
    else     begin bus.a_wen = 1; bus.a_addr = IW'(addr); bus.a_in = v; end
    @(posedge clk); #1;
    bus.a_wen = 0; bus.b_wen = 0;
    if (addr < DEPTH) begin
      if (isb) mb[addr] = v; else ma[addr] = v;
    end
  endtask

  // rmode: 0 ready always, 1 alternating, 2 random. abort_hs>0 resets after that many handshakes.
  task automatic run(input logic [1:0] o, input int rmode, input bit mid_start, input bit mid_wr,
                     input int abort_hs);
    logic signed [DW-1:0] r;
    bit v;
    exp_q.delete(); exp_ovf = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model(o, ma[i], mb[i], r, v);
      exp_q.push_back(r);
      exp_ovf |= v;
    end
    exp_i = 0; hs = 0; done_seen = 0; chk_en = 1;
    @(posedge clk); #1;
    bus.start = 1; bus.op = o; bus.c_ready = 1;
    @(posedge clk); #1;
    start_cyc = cyc; bus.start = 0;
    for (int k = 0; k < 300 && !done_seen; k++) begin
      if (abort_hs > 0 && hs >= abort_hs) break;
      bus.c_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      bus.start   = mid_start && (k == 3);
      bus.op      = (mid_start && k == 3) ? ~o : o;
      bus.a_wen   = mid_wr && (k == 2);
      bus.a_addr  = '0;
      bus.a_in    = $urandom;
      @(posedge clk); #1;
    end
    bus.start = 0; bus.a_wen = 0; bus.c_ready = 1;
    if (abort_hs > 0) begin
      #2 rst = 1; chk_en = 0;
      #1;
      chk("rst_c_valid", bus.c_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_c_idx", bus.c_idx, 0);
      exp_q.delete();
      @(negedge clk); rst = 0;
    end else begin
      if (!done_seen) chk("done_timeout", 0, 1);
      if (rmode == 0) chk("done_latency", done_cyc - start_cyc, DEPTH + 1);
      chk("handshakes", hs, DEPTH);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    bus.start = 0; bus.op = 0; bus.a_in = 0; bus.b_in = 0; bus.a_addr = 0; bus.b_addr = 0;
    bus.a_wen = 0; bus.b_wen = 0; bus.c_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_c_valid", bus.c_valid, 0);
    chk("reset_c_out", bus.c_out, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ovf", bus.ovf, 0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < DEPTH; i++) begin wr(0, i, DW'(i)); wr(1, i, DW'(10 * i)); end
    run(2'd0, 0, 0, 0, 0);
    chk("lit_add_1", obs[1], 11);
    chk("lit_add_8", obs[8], 88);
    chk("lit_add_ovf", ovf_at_done, 0);

    for (int i = 0; i < DEPTH; i++) begin wr(0, i, 32'd5); wr(1, i, DW'(i)); end
    run(2'd2, 1, 0, 0, 0);
    chk("lit_bma_0", obs[0], -5);
    chk("lit_bma_8", obs[8], 3);

    wr(0, 0, 32'h7fffffff); wr(1, 0, 32'd1);
    run(2'd0, 0, 0, 0, 0);
`ifdef MATRIX_SATURATE_EN
    chk("lit_ovf_add", obs[0], 64'sd2147483647);
`else
    chk("lit_ovf_add", obs[0], -64'sd2147483648);
`endif
    chk("lit_ovf_flag", ovf_at_done, 1);

    wr(0, 0, 32'h80000000);
    run(2'd1, 2, 0, 0, 0);
`ifdef MATRIX_SATURATE_EN
    chk("lit_ovf_sub", obs[0], -64'sd2147483648);
`else
    chk("lit_ovf_sub", obs[0], 64'sd2147483647);
`endif

    wr(0, 0, -32'sd3); wr(1, 0, 32'd0);
    run(2'd3, 0, 0, 0, 0);
    chk("lit_mean", obs[0], -2);
    chk("lit_mean_ovf", ovf_at_done, 0);

    wr(0, 9, 32'd12345);
    run(2'd0, 2, 1, 1, 0);
    run(2'd1, 0, 0, 0, 4);
    run(2'd0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int s = 0; s < 2; s++) begin
          case ($urandom_range(0, 3))
            0: v = 32'h7fffffff;
            1: v = 32'h80000000;
            2: v = DW'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
          endcase
          wr(s[0], i, v);
        end
      end
      if ($urandom_range(0, 1) == 1) wr(0, $urandom_range(DEPTH, 15), $urandom);
      run(2'($urandom_range(0, 3)), $urandom_range(0, 2), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matrix_elementwise_mxp.md
# matrix_elementwise_mxp

Parametrised M×P element-wise matrix engine, successor to the 3×3 add/subtract calculator in the robot-tracker math path. It holds operands A and B in internal register arrays and, on `start`, streams one result per accepted handshake in row-major index order. Operations are A+B, A−B, B−A and the arithmetic mean (A+B)>>>1. The output stage has valid/ready backpressure and a sticky overflow flag.

## Interface
- `M`, 3, row count (≥1)
- `P`, 3, column count (≥1)
- `DATA_WIDTH`, 32, signed element width
- `IDX_W`, 4, index width; must satisfy 2^IDX_W ≥ M*P
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `op`  in  2  00 A+B, 01 A−B, 10 B−A, 11 (A+B)>>>1; latched at start
- `a_in` / `b_in`  in  DATA_WIDTH  signed write data
- `a_addr` / `b_addr`  in  IDX_W  write index
- `a_wen` / `b_wen`  in  1  write enables
- `c_out`  out  DATA_WIDTH  signed result
- `c_idx`  out  IDX_W  index of `c_out`
- `c_valid`  out  1  result valid
- `c_ready`  in  1  consumer ready
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of run
- `ovf`  out  1  sticky overflow for the current run

## Operation
- **Storage**
  - A and B are not reset.
  - A write lands when wen=1, addr < M*P and state = IDLE.
  - Writes with addr ≥ M*P are dropped.
  - Writes while busy are dropped.
  - A write in the same cycle that start is accepted does land.
- **States**
  - IDLE: start=1 → RUN. On that edge: idx←0, op latched, ovf←0.
  - RUN: the output slot is free when !c_valid || c_ready. When free, load c_out=f(A[idx],B[idx]), c_idx←idx, c_valid←1, idx←idx+1. Loading index M*P−1 → FLUSH.
  - FLUSH: when c_valid && c_ready, set c_valid←0 and done←1, then → IDLE.
- `start` is ignored outside IDLE.
- **Arithmetic**
  - Each result is computed at DATA_WIDTH+1 bits.
  - Overflow means the DATA_WIDTH+1-bit result does not fit in DATA_WIDTH bits.
  - On overflow, ovf←1. It stays set until the next accepted start or reset.
  - Mode 11 is an arithmetic right shift of the wide sum, so it floors and never overflows.
- **Output stability:** while c_valid=1 and c_ready=0, c_out and c_idx hold.
- **Reset** (asynchronous, any time, including mid-run):
  - State → IDLE; idx=0.
  - c_out=0, c_idx=0, c_valid=0, done=0, ovf=0; busy=0.
  - Array contents are retained.

## Timing
- With start sampled at edge 0 and c_ready held at 1:
  - c_valid is high in the cycles after edges 1…M*P, with one new element per cycle.
  - done is high for one cycle after edge M*P+1. busy is already 0 in that cycle.
- Throughput is one element per cycle when unstalled. Backpressure inserts no extra bubbles.
- M*P=1: RUN loads element 0 and goes to FLUSH on the same edge.
- done and c_valid are never high together.

## Configuration
- `MATRIX_SATURATE_EN`
  - Defined: overflowing results clamp to +2^(DATA_WIDTH−1)−1 or −2^(DATA_WIDTH−1).
  - Undefined: results wrap (two's-complement truncation).
  - ovf is set identically in both builds.

## Test plan
- **Basic add, no stall:** A[i]=i, B[i]=10i, op=00, c_ready=1, start → nine consecutive valids with c_out 0,11,…,88 and c_idx 0…8; done one cycle after the last valid; ovf=0.
- **B−A with backpressure:** A[i]=5, B[i]=i, op=10, c_ready alternating 1/0 → c_out −5…3 in order; values held while stalled; done after the 9th handshake.
- **Overflow:**
  - A[0]=0x7FFFFFFF, B[0]=1, op=00 → wrap build c_out=0x80000000, saturate build 0x7FFFFFFF; ovf=1 in both.
  - op=01 with A=0x80000000, B=1 → 0x7FFFFFFF (wrap) or 0x80000000 (saturate).
- **Mean mode:** A[0]=−3, B[0]=0, op=11 → c_out=−2, ovf=0.
- **Ignored inputs:**
  - start pulsed mid-run → no restart; exactly 9 outputs.
  - a_wen mid-run → A unchanged.
  - a_addr=9 write in IDLE → ignored.
- **Reset mid-run:** rst asserted after 4 handshakes → c_valid, done and busy go to 0 immediately without a clock edge; the next start produces all 9 elements from index 0.
